// File: rtl/count_sampler.sv
// Periodic sampler for the event counter: requests a read every PERIOD cycles,
// converts the returned count into a per-interval delta and queues {seq, delta}.
module count_sampler #(
  parameter int CNT_W      = 32,
  parameter int PERIOD     = 16,
  parameter int TIMEOUT    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ATOMIC     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             clear_i,
  output logic             req_o,
  output logic             atomic_o,
  input  logic             ack_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             smp_valid_o,
  input  logic             smp_ready_i,
  output logic [CNT_W-1:0] smp_delta_o,
  output logic [7:0]       smp_seq_o,
  output logic             overflow_o,
  output logic             timeout_o
);
  localparam int PW = $clog2(PERIOD);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] PCNT_MAX = PW'(PERIOD - 1);
  localparam logic [WW-1:0] WCNT_MAX = WW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, PUSH} state_t;

  state_t             state_q, state_d;
  logic               en_q, en_d;
  logic [PW-1:0]      pcnt_q, pcnt_d;
  logic [WW-1:0]      wcnt_q, wcnt_d;
  logic               req_q, req_d;
  logic [CNT_W-1:0]   last_q, last_d;
  logic [7:0]         seq_q, seq_d;
  logic [AW:0]        wptr_q, wptr_d;
  logic [AW:0]        rptr_q, rptr_d;
  logic               overflow_q, overflow_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   delta_q, delta_d;
  logic [CNT_W+7:0]   mem_q [FIFO_DEPTH];

  logic               tick, empty, full, push, pop;
  logic [CNT_W+7:0]   head;

  assign tick  = (pcnt_q == PCNT_MAX);
  assign empty = (wptr_q == rptr_q);
  // Full is judged on pre-edge pointers, so a same-cycle pop never rescues a push.
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push  = (state_q == PUSH) && !full;
  assign pop   = !empty && smp_ready_i;
  assign head  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    state_d    = state_q;
    en_d       = enable_i;
    pcnt_d     = (!en_q || tick) ? '0 : pcnt_q + PW'(1);
    wcnt_d     = wcnt_q;
    req_d      = req_q;
    last_d     = last_q;
    seq_d      = seq_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    delta_d    = delta_q;
    overflow_d = clear_i ? 1'b0 : overflow_q;
    timeout_d  = clear_i ? 1'b0 : timeout_q;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = REQ;
          req_d   = 1'b1;
          wcnt_d  = '0;
        end
      end
      REQ: begin
        if (ack_i) begin
          state_d = PUSH;
          req_d   = 1'b0;
          last_d  = count_i;
          delta_d = (ATOMIC != 0) ? count_i : count_i - last_q;
        end else if (wcnt_q == WCNT_MAX) begin
          state_d   = IDLE;
          req_d     = 1'b0;
          timeout_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      PUSH: begin
        state_d = IDLE;
        seq_d   = seq_q + 8'd1;
        if (full) overflow_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (push) wptr_d = wptr_q + (AW+1)'(1);
    if (pop)  rptr_d = rptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      en_q       <= 1'b0;
      pcnt_q     <= '0;
      wcnt_q     <= '0;
      req_q      <= 1'b0;
      last_q     <= '0;
      seq_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      pcnt_q     <= pcnt_d;
      wcnt_q     <= wcnt_d;
      req_q      <= req_d;
      last_q     <= last_d;
      seq_q      <= seq_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    delta_q <= delta_d;
    if (push) mem_q[wptr_q[AW-1:0]] <= {seq_q, delta_q};
  end

  assign req_o       = req_q;
  assign atomic_o    = req_q & (ATOMIC != 0);
  assign smp_valid_o = !empty;
  assign smp_delta_o = empty ? '0 : head[CNT_W-1:0];
  assign smp_seq_o   = empty ? 8'd0 : head[CNT_W+7:CNT_W];
  assign overflow_o  = overflow_q;
  assign timeout_o   = timeout_q;
endmodule

// File: doc/count_sampler.md
# count_sampler

Periodic sampler that sits directly downstream of the atomic event counter. It issues read requests to the counter on a fixed interval and captures the returned count on acknowledge. It then computes the per-interval delta and queues `{seq, delta}` records in a small FIFO for a valid/ready consumer. Timeouts and dropped samples are flagged through sticky status bits.

## Interface
- `CNT_W`, default 32: width of the counter value and of the delta.
- `PERIOD`, default 16: sample interval in clock cycles. Legal range is PERIOD >= TIMEOUT+3.
- `TIMEOUT`, default 8: maximum number of cycles the block waits for `ack_i`.
- `FIFO_DEPTH`, default 4: number of sample FIFO entries. Must be a power of 2, at least 2.
- `ATOMIC`, default 0: 1 selects read-and-clear reads, so the delta equals the raw count.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `enable_i`  in  1  runs the period counter.
- `clear_i`  in  1  one-cycle pulse that clears `overflow_o` and `timeout_o`.
- `req_o`  out  1  read request to the counter; registered.
- `atomic_o`  out  1  equals `ATOMIC` while `req_o` is high, else 0.
- `ack_i`  in  1  counter acknowledge; single-cycle pulse.
- `count_i`  in  CNT_W  counter value; valid only in the cycle `ack_i` is high.
- `smp_valid_o`  out  1  FIFO head valid.
- `smp_ready_i`  in  1  consumer accepts the head.
- `smp_delta_o`  out  CNT_W  delta at the FIFO head.
- `smp_seq_o`  out  8  sequence number at the FIFO head.
- `overflow_o`  out  1  sticky: a sample was dropped because the FIFO was full.
- `timeout_o`  out  1  sticky: a request expired without acknowledge.

## Operation
- **FSM states:**
  - IDLE: when `tick` occurs, go to REQ; `req_o` is 1 from the next cycle.
  - REQ: on `ack_i`, capture `count_i` and go to PUSH. If the wait counter reaches TIMEOUT, set `timeout_o` and go to IDLE.
  - PUSH: write one FIFO entry (or drop it), then go to IDLE.
- **Period counter:**
  - Counts 0..PERIOD-1 while `enable_i`=1 and is held at 0 while `enable_i`=0.
  - `tick` is asserted when the counter equals PERIOD-1.
  - A `tick` that occurs outside IDLE is discarded; there is no backlog.
- **Disable mid-request:** deasserting `enable_i` does not abort REQ or PUSH; the request in flight completes.
- **Request handshake:**
  - `req_o` is high for every cycle spent in REQ.
  - The wait counter starts at 0 on entry to REQ and increments each REQ cycle.
  - `ack_i` seen in any state other than REQ is ignored.
- **Ack/timeout collision:** if `ack_i` arrives in the same cycle the wait counter hits TIMEOUT, the ack wins. The sample is captured and `timeout_o` is not set.
- **Delta arithmetic:**
  - ATOMIC=0: delta = `count_i` - `last`, modulo 2^CNT_W, so counter wrap yields the correct small delta. `last` <= `count_i` on every capture, including dropped samples.
  - ATOMIC=1: delta = `count_i`, and `last` is unused.
  - `last` resets to 0, so the first sample's delta equals the raw count.
- **Sequence number:** `seq` is 8 bits, resets to 0, and increments on every PUSH whether stored or dropped, wrapping 255 -> 0. The record carries the pre-increment value, so a consumer sees gaps when samples are dropped.
- **FIFO:**
  - First-word-fall-through; `smp_valid_o` = not empty.
  - A pop happens when `smp_valid_o` & `smp_ready_i`.
  - The full check uses the pre-edge state: a PUSH into a full FIFO is dropped even if a pop occurs in the same cycle, and `overflow_o` is set.
- **Sticky status:** `clear_i` clears both sticky bits. A set event in the same cycle as `clear_i` wins.

## Timing
- **Reset values:**
  - `req_o`, `atomic_o`, `smp_valid_o`, `overflow_o`, `timeout_o` = 0.
  - `smp_delta_o`, `smp_seq_o` = 0.
  - FSM = IDLE; period counter, wait counter, `last`, `seq` = 0; FIFO empty.
- **Reset mid-operation:** asserting `reset` in any state immediately drops `req_o` and empties the FIFO.
- **First request:** `enable_i` rises before edge 0 -> `tick` is high in the cycle following edge PERIOD-1 -> `req_o` rises after edge PERIOD.
- **Subsequent requests:** `req_o` rises every PERIOD cycles, provided the ack returns within PERIOD-3 cycles.
- **Ack to output:** `ack_i` sampled high at edge N -> `req_o` low after N -> FIFO write at edge N+1 -> `smp_valid_o` high after N+1.
- **Timeout:** `req_o` stays high for exactly TIMEOUT+1 cycles, then drops; `timeout_o` rises in the same edge.
- **Consumer:** the head updates one cycle after a pop.

## Test plan
- **Basic sampling:** PERIOD=16, ATOMIC=0; the counter returns 5, 12, 30 with a 2-cycle ack delay -> records {0,5}, {1,7}, {2,18}; `smp_valid_o` rises 2 cycles after each ack.
- **Wrap-around:** `last`=0xFFFFFFF0, next `count_i`=0x00000010 -> delta 0x20.
- **Atomic mode:** ATOMIC=1, the counter returns 9 then 4 -> `atomic_o`=1 with every `req_o`; deltas 9, 4.
- **Timeout:** `ack_i` never asserted -> `req_o` high for 9 cycles, then `timeout_o`=1, no record, next request issued on the next `tick`.
- **Timeout collision:** `ack_i` at the expiry cycle -> sample captured and `timeout_o` stays 0.
- **Overflow:** `smp_ready_i`=0 for 6 samples with FIFO_DEPTH=4 -> `overflow_o`=1. The FIFO holds seq 0..3; after draining, the next record is seq 6. `clear_i` then clears `overflow_o`.
- **Reset in REQ:** `reset` pulsed mid-request -> `req_o` drops asynchronously, FIFO empty, and the first delta after reset equals the raw count.
